// File: rtl/bias_act_unit_if.sv
// DRAM-side bus of the bias/activation unit: one read port with a shared
// accept strobe and one registered write port.
interface bias_act_unit_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18
);
  logic                         dram_valid;
  logic signed [DATA_WIDTH-1:0] data_in;
  logic signed [DATA_WIDTH-1:0] data_out;
  logic        [ADDR_WIDTH-1:0] addr_in;
  logic        [ADDR_WIDTH-1:0] addr_out;
  logic                         dram_en_rd;
  logic                         dram_en_wr;

  modport master (
    input  dram_valid, data_in,
    output data_out, addr_in, addr_out, dram_en_rd, dram_en_wr
  );

  modport slave (
    output dram_valid, data_in,
    input  data_out, addr_in, addr_out, dram_en_rd, dram_en_wr
  );
endinterface

// File: rtl/bias_act_unit.sv
// Per-channel bias-add + activation post-processor: loads layer params and
// biases from DRAM, then streams every pixel through saturating add and activation.
module bias_act_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int KNL_MAXNUM = 16,
  parameter int DIM_BITS   = 5,
  parameter int PARAM_BASE = 0,
  parameter int BIAS_BASE  = 61440,
  parameter int FMAP_BASE  = 131072,
  parameter int OUT_BASE   = 131072,
  parameter int LEAK_SHIFT = 3,
  parameter logic signed [DATA_WIDTH-1:0] CLAMP_MAX = DATA_WIDTH'(32'h0000_7FFF)
) (
  input  logic            clk,
  input  logic            srst,
  input  logic            enable,
  bias_act_unit_if.master bus,
  output logic            done,
  output logic            err
);

  typedef enum logic [2:0] {IDLE, LD_PARAM, LD_BIAS, CHECK, EVAL, DRAIN, DONE} state_t;

  localparam int CW = (KNL_MAXNUM > 1) ? $clog2(KNL_MAXNUM) : 1;
  localparam int OW = CW + 2 * DIM_BITS;
  localparam logic [DATA_WIDTH-1:0] DIM_MAX   = DATA_WIDTH'(1 << DIM_BITS);
  localparam logic [DATA_WIDTH-1:0] DEPTH_MAX = DATA_WIDTH'(KNL_MAXNUM);
  localparam logic [DATA_WIDTH-1:0] ONE       = DATA_WIDTH'(1);
  localparam logic signed [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  function automatic logic signed [DATA_WIDTH-1:0] sat_add(
    input logic signed [DATA_WIDTH-1:0] a,
    input logic signed [DATA_WIDTH-1:0] b
  );
    logic signed [DATA_WIDTH:0] s;
    s = $signed({a[DATA_WIDTH-1], a}) + $signed({b[DATA_WIDTH-1], b});
    if (s[DATA_WIDTH] != s[DATA_WIDTH-1]) begin
      return s[DATA_WIDTH] ? SAT_MIN : SAT_MAX;
    end
    return $signed(s[DATA_WIDTH-1:0]);
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] activate(
    input logic signed [DATA_WIDTH-1:0] p,
    input logic        [1:0]            m
  );
    logic signed [DATA_WIDTH-1:0] r;
    case (m)
      2'd1:    r = (p < 0) ? '0 : p;
      2'd2:    r = (p < 0) ? (p >>> LEAK_SHIFT) : p;
      2'd3:    r = (p < 0) ? '0 : ((p > CLAMP_MAX) ? CLAMP_MAX : p);
      default: r = p;
    endcase
    return r;
  endfunction

  state_t                       state;
  logic [1:0]                   k;
  logic [CW-1:0]                c;
  logic [DIM_BITS-1:0]          h;
  logic [DIM_BITS-1:0]          w;
  logic [DATA_WIDTH-1:0]        width_r;
  logic [DATA_WIDTH-1:0]        height_r;
  logic [DATA_WIDTH-1:0]        depth_r;
  logic [1:0]                   mode_r;
  logic signed [DATA_WIDTH-1:0] biases [KNL_MAXNUM];

  logic                         par_vld_p0;
  logic                         bias_vld_p0;
  logic                         wr_vld_p0;
  logic [1:0]                   k_p0;
  logic [CW-1:0]                idx_p0;
  logic [CW-1:0]                chan_p0;
  logic [ADDR_WIDTH-1:0]        addr_out_p0;

  logic [OW-1:0]                pix_off;
  logic                         last_w, last_h, last_c, last_bias, param_bad;

  assign pix_off = {c, h, w};
  assign last_w  = (DATA_WIDTH'(w) == width_r - ONE);
  assign last_h  = (DATA_WIDTH'(h) == height_r - ONE);
  assign last_c  = (DATA_WIDTH'(c) == depth_r - ONE);
  // Bias loading also stops at the register-file end so an oversized depth
  // cannot overrun biases[]; CHECK then flags it.
  assign last_bias = (depth_r == '0) || last_c || (c == CW'(KNL_MAXNUM - 1));
  assign param_bad = (width_r == '0)  || (width_r > DIM_MAX)  ||
                     (height_r == '0) || (height_r > DIM_MAX) ||
                     (depth_r == '0)  || (depth_r > DEPTH_MAX);

  always_comb begin
    bus.addr_in = '0;
    case (state)
      LD_PARAM: bus.addr_in = ADDR_WIDTH'(PARAM_BASE) + ADDR_WIDTH'(k);
      LD_BIAS:  bus.addr_in = ADDR_WIDTH'(BIAS_BASE) + ADDR_WIDTH'(c);
      EVAL:     bus.addr_in = ADDR_WIDTH'(FMAP_BASE) + ADDR_WIDTH'(pix_off);
      default:  bus.addr_in = '0;
    endcase
  end

  assign bus.dram_en_rd = (state == LD_PARAM) || (state == LD_BIAS) || (state == EVAL);
  assign bus.dram_en_wr = wr_vld_p0;
  assign bus.addr_out   = addr_out_p0;

  // Stage p0: read data returns; bias-add and activation on the returned pixel
  assign bus.data_out = activate(sat_add(bus.data_in, biases[chan_p0]), mode_r);

  always_ff @(posedge clk) begin
    if (srst) begin
      state       <= IDLE;
      k           <= '0;
      c           <= '0;
      h           <= '0;
      w           <= '0;
      width_r     <= '0;
      height_r    <= '0;
      depth_r     <= '0;
      mode_r      <= '0;
      for (int i = 0; i < KNL_MAXNUM; i++) biases[i] <= '0;
      par_vld_p0  <= 1'b0;
      bias_vld_p0 <= 1'b0;
      wr_vld_p0   <= 1'b0;
      k_p0        <= '0;
      idx_p0      <= '0;
      chan_p0     <= '0;
      addr_out_p0 <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
    end else begin
      par_vld_p0  <= (state == LD_PARAM) && bus.dram_valid;
      bias_vld_p0 <= (state == LD_BIAS) && bus.dram_valid;
      wr_vld_p0   <= (state == EVAL) && bus.dram_valid;
      k_p0        <= k;
      idx_p0      <= c;
      if ((state == EVAL) && bus.dram_valid) begin
        chan_p0     <= c;
        addr_out_p0 <= ADDR_WIDTH'(OUT_BASE) + ADDR_WIDTH'(pix_off);
      end

      if (par_vld_p0) begin
        case (k_p0)
          2'd0:    width_r  <= bus.data_in;
          2'd1:    height_r <= bus.data_in;
          2'd2:    depth_r  <= bus.data_in;
          default: mode_r   <= bus.data_in[1:0];
        endcase
      end
      if (bias_vld_p0) biases[idx_p0] <= bus.data_in;

      done <= 1'b0;
      case (state)
        IDLE: begin
          if (enable) begin
            err   <= 1'b0;
            k     <= '0;
            c     <= '0;
            state <= LD_PARAM;
          end
        end
        LD_PARAM: begin
          if (bus.dram_valid) begin
            k <= k + 2'd1;
            if (k == 2'd3) state <= LD_BIAS;
          end
        end
        LD_BIAS: begin
          if (bus.dram_valid) begin
            if (last_bias) begin
              c     <= '0;
              state <= CHECK;
            end else begin
              c <= c + 1'b1;
            end
          end
        end
        CHECK: begin
          w <= '0;
          h <= '0;
          c <= '0;
          if (param_bad) begin
            err   <= 1'b1;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= EVAL;
          end
        end
        EVAL: begin
          if (bus.dram_valid) begin
            if (last_w) begin
              w <= '0;
              if (last_h) begin
                h <= '0;
                if (last_c) begin
                  c     <= '0;
                  state <= DRAIN;
                end else begin
                  c <= c + 1'b1;
                end
              end else begin
                h <= h + 1'b1;
              end
            end else begin
              w <= w + 1'b1;
            end
          end
        end
        DRAIN: begin
          done  <= 1'b1;
          state <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bias_act_unit.sv
// Directed bench for bias_act_unit: behavioural DRAM with optional accept
// stalls, hand-computed expected writes per scenario.
module tb_bias_act_unit;
  localparam int DW    = 32;
  localparam int AW    = 18;
  localparam int PBASE = 0;
  localparam int BBASE = 61440;
  localparam int FMAP  = 131072;
  localparam int OBASE = 131072;

  logic clk = 1'b0;
  logic srst;
  logic enable;
  logic done;
  logic err;

  bias_act_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  bias_act_unit #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .KNL_MAXNUM(16), .DIM_BITS(5),
    .PARAM_BASE(PBASE), .BIAS_BASE(BBASE), .FMAP_BASE(FMAP), .OUT_BASE(OBASE),
    .LEAK_SHIFT(3), .CLAMP_MAX(32'h0000_7FFF)
  ) dut (
    .clk(clk), .srst(srst), .enable(enable), .bus(bus), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  logic [31:0]   mem [0:(1<<AW)-1];
  logic [AW-1:0] wr_addr_q [$];
  logic [31:0]   wr_data_q [$];
  int  cyc = 0, done_cnt = 0, done_cyc = 0, last_wr_cyc = 0;
  int  rej_eval = 0, rej_then_wr = 0;
  bit  stall_en = 1'b0;
  int  n_cmp = 0, n_fail = 0;

  int ch0_px  [8]  = '{-3, 0, 1, 2, -8, -5, 100, 7};
  int ch1_px  [8]  = '{9, 12, -4, 10, 20, 0, 11, 30};
  int exp_out [16] = '{2, 5, 6, 7, 0, 0, 105, 12, 0, 2, 0, 0, 10, 0, 1, 20};

  // DRAM model: observe mid-cycle, return accepted read data just after the edge
  initial begin : dram_model
    bit acc, rej_prev;
    logic [AW-1:0] a;
    rej_prev       = 1'b0;
    bus.dram_valid = 1'b1;
    bus.data_in    = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (bus.dram_en_wr) begin
        wr_addr_q.push_back(bus.addr_out);
        wr_data_q.push_back(bus.data_out);
        last_wr_cyc = cyc;
        if (rej_prev) rej_then_wr++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      acc      = bus.dram_en_rd && bus.dram_valid;
      rej_prev = bus.dram_en_rd && !bus.dram_valid && (bus.addr_in >= AW'(FMAP));
      if (rej_prev) rej_eval++;
      a = bus.addr_in;
      @(posedge clk);
      #1;
      if (acc) bus.data_in = mem[a];
      bus.dram_valid = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  task automatic clear_obs();
    wr_addr_q.delete();
    wr_data_q.delete();
    done_cnt    = 0;
    rej_eval    = 0;
    rej_then_wr = 0;
  endtask

  task automatic run_job(input string tag);
    @(posedge clk); #1; enable = 1'b1;
    @(posedge clk); #1; enable = 1'b0;
    for (int i = 0; i < 2000 && done_cnt == 0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (done_cnt == 0) begin
      n_fail++;
      $display("FAIL %s_timeout: done pulses got %0d required >0 within 2000 cycles", tag, done_cnt);
    end
  endtask

  task automatic load_main();
    mem[PBASE+0] = 4; mem[PBASE+1] = 2; mem[PBASE+2] = 2; mem[PBASE+3] = 1;
    mem[BBASE+0] = 32'd5;
    mem[BBASE+1] = 32'hFFFF_FFF6;
    for (int i = 0; i < 8; i++) begin
      mem[FMAP + (i/4)*32 + (i%4)]        = ch0_px[i];
      mem[FMAP + 1024 + (i/4)*32 + (i%4)] = ch1_px[i];
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp += 5;
    if (bus.addr_out !== '0)   begin n_fail++; $display("FAIL reset_addr_out: got %0h required 0", bus.addr_out); end
    if (bus.dram_en_wr !== 0)  begin n_fail++; $display("FAIL reset_en_wr: got %0b required 0", bus.dram_en_wr); end
    if (bus.dram_en_rd !== 0)  begin n_fail++; $display("FAIL reset_en_rd: got %0b required 0", bus.dram_en_rd); end
    if (done !== 0)            begin n_fail++; $display("FAIL reset_done: got %0b required 0", done); end
    if (err !== 0)             begin n_fail++; $display("FAIL reset_err: got %0b required 0", err); end
    @(posedge clk); #1; srst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_main_job(input bit stall, input string tag);
    logic [AW-1:0] ea;
    load_main();
    clear_obs();
    stall_en = stall;
    run_job(tag);
    stall_en = 1'b0;
    n_cmp++;
    if (wr_addr_q.size() != 16) begin
      n_fail++; $display("FAIL %s_write_count: got %0d required 16", tag, wr_addr_q.size());
    end
    for (int i = 0; i < 16; i++) begin
      ea = AW'(OBASE + (i/8)*1024 + ((i%8)/4)*32 + (i%4));
      n_cmp += 2;
      if (i >= int'(wr_addr_q.size())) begin
        n_fail += 2; $display("FAIL %s_write%0d: missing, required addr %0h data %0d", tag, i, ea, exp_out[i]);
      end else begin
        if (wr_addr_q[i] !== ea) begin
          n_fail++; $display("FAIL %s_addr%0d: got %0h required %0h", tag, i, wr_addr_q[i], ea);
        end
        if (wr_data_q[i] !== 32'(exp_out[i])) begin
          n_fail++; $display("FAIL %s_data%0d: got %0d required %0d", tag, i, $signed(wr_data_q[i]), exp_out[i]);
        end
      end
    end
    n_cmp += 3;
    if (done_cnt != 1) begin n_fail++; $display("FAIL %s_done_pulses: got %0d required 1", tag, done_cnt); end
    if (done_cyc != last_wr_cyc + 1) begin
      n_fail++; $display("FAIL %s_done_timing: done cycle %0d required %0d", tag, done_cyc, last_wr_cyc + 1);
    end
    if (err !== 0) begin n_fail++; $display("FAIL %s_err: got %0b required 0", tag, err); end
    if (stall) begin
      n_cmp += 2;
      if (rej_then_wr != 0) begin n_fail++; $display("FAIL %s_write_after_reject: got %0d required 0", tag, rej_then_wr); end
      if (rej_eval == 0)    begin n_fail++; $display("FAIL %s_stall_seen: rejected pixel reads got 0 required >0", tag); end
    end
  endtask

  task automatic test_single();
    int          md [9] = '{2, 3, 0, 0, 0, 3, 2, 1, 2};
    logic [31:0] px [9] = '{32'hFFFF_FFB0, 32'd40000, 32'hFFFF_FFF9, 32'h7FFF_FFF0, 32'h8000_0000,
                            32'hFFFF_FFFB, 32'd24, 32'h7FFF_FFF0, 32'h8000_0000};
    logic [31:0] bs [9] = '{32'd0, 32'd0, 32'd2, 32'h20, 32'hFFFF_FFFF,
                            32'd0, 32'd0, 32'h20, 32'hFFFF_FFFF};
    logic [31:0] ex [9] = '{32'hFFFF_FFF6, 32'd32767, 32'hFFFF_FFFB, 32'h7FFF_FFFF, 32'h8000_0000,
                            32'd0, 32'd24, 32'h7FFF_FFFF, 32'hF000_0000};
    for (int t = 0; t < 9; t++) begin
      mem[PBASE+0] = 1; mem[PBASE+1] = 1; mem[PBASE+2] = 1; mem[PBASE+3] = md[t];
      mem[BBASE]   = bs[t];
      mem[FMAP]    = px[t];
      clear_obs();
      run_job("single");
      n_cmp++;
      if (wr_addr_q.size() != 1) begin
        n_fail++; $display("FAIL single%0d_count: got %0d required 1", t, wr_addr_q.size());
      end else begin
        n_cmp += 2;
        if (wr_addr_q[0] !== AW'(OBASE)) begin
          n_fail++; $display("FAIL single%0d_addr: got %0h required %0h", t, wr_addr_q[0], OBASE);
        end
        if (wr_data_q[0] !== ex[t]) begin
          n_fail++; $display("FAIL single%0d_data: got %0h required %0h", t, wr_data_q[0], ex[t]);
        end
      end
    end
  endtask

  task automatic test_errors();
    int ew [3] = '{4, 0, 4};
    int eh [3] = '{2, 2, 33};
    int ed [3] = '{17, 2, 1};
    for (int j = 0; j < 17; j++) mem[BBASE + j] = j;
    for (int t = 0; t < 3; t++) begin
      mem[PBASE+0] = ew[t]; mem[PBASE+1] = eh[t]; mem[PBASE+2] = ed[t]; mem[PBASE+3] = 1;
      clear_obs();
      run_job("err");
      n_cmp += 3;
      if (err !== 1) begin n_fail++; $display("FAIL err%0d_flag: got %0b required 1", t, err); end
      if (done_cnt != 1) begin n_fail++; $display("FAIL err%0d_done: got %0d required 1", t, done_cnt); end
      if (wr_addr_q.size() != 0) begin n_fail++; $display("FAIL err%0d_writes: got %0d required 0", t, wr_addr_q.size()); end
    end
    test_main_job(1'b0, "recover");
  endtask

  task automatic test_srst_mid();
    int n;
    load_main();
    clear_obs();
    @(posedge clk); #1; enable = 1'b1;
    @(posedge clk); #1; enable = 1'b0;
    for (int i = 0; i < 200 && wr_addr_q.size() < 4; i++) @(negedge clk);
    n_cmp++;
    if (wr_addr_q.size() < 4) begin
      n_fail++; $display("FAIL srst_reach_eval: writes got %0d required >=4", wr_addr_q.size());
    end
    @(posedge clk); #1; srst = 1'b1;
    @(posedge clk); #1; srst = 1'b0;
    @(negedge clk);
    n_cmp += 4;
    if (bus.dram_en_wr !== 0) begin n_fail++; $display("FAIL srst_en_wr: got %0b required 0", bus.dram_en_wr); end
    if (bus.addr_out !== '0)  begin n_fail++; $display("FAIL srst_addr_out: got %0h required 0", bus.addr_out); end
    if (bus.dram_en_rd !== 0) begin n_fail++; $display("FAIL srst_idle: en_rd got %0b required 0", bus.dram_en_rd); end
    if (done !== 0)           begin n_fail++; $display("FAIL srst_done: got %0b required 0", done); end
    n = wr_addr_q.size();
    repeat (6) @(negedge clk);
    n_cmp++;
    if (wr_addr_q.size() != n) begin
      n_fail++; $display("FAIL srst_no_write: writes got %0d required %0d", wr_addr_q.size(), n);
    end
    test_main_job(1'b0, "srst_rerun");
  endtask

  initial begin
    srst   = 1'b1;
    enable = 1'b0;
    test_reset();
    test_main_job(1'b0, "basic");
    test_single();
    test_main_job(1'b1, "stall");
    test_errors();
    test_srst_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
